// File: rtl/mioc_dram_seq.sv
// ============================================================================
// Module   : mioc_dram_seq
// Brief    : DRAM cycle sequencer and Z80/6801 bus arbiter for mioc_top.
//            Generates RAS_N/MUX/CAS1_N/CAS2_N/RA7 timing.
//            Also owns the BUSRQ_N/BUSAK_N hand-over for DMA.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mioc_dram_seq #(
    parameter int PRECH_CYC = 1,
    parameter int RFSH_CYC  = 2
) (
    input  logic B_PHI,
    input  logic RST_N,
    input  logic BMREQ_N,
    input  logic BRD_N,
    input  logic N_BWR,
    input  logic BRFSH_N,
    input  logic DMA_N,
    input  logic BUSAK_N,
    input  logic INTRAM_SEL,
    input  logic EXPRAM_SEL,
    input  logic BA7,
    input  logic BA15,
    output logic RAS_N,
    output logic MUX,
    output logic CAS1_N,
    output logic CAS2_N,
    output logic RA7,
    output logic BUSRQ_N,
    output logic ADDRBUFEN_N,
    output logic DMA_GNT
);

    localparam logic [1:0] c_RFSH_LOAD  = 2'(RFSH_CYC - 1);
    localparam logic [1:0] c_PRECH_LOAD = 2'(PRECH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROW   = 3'd1,
        S_COL   = 3'd2,
        S_HOLD  = 3'd3,
        S_RFSH  = 3'd4,
        S_PRECH = 3'd5
    } cyc_state_t;

    typedef enum logic [1:0] {
        A_CPU = 2'd0,
        A_REQ = 2'd1,
        A_DMA = 2'd2,
        A_REL = 2'd3
    } arb_state_t;

    cyc_state_t cyc_q, cyc_d;
    arb_state_t arb_q, arb_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bank2_q, bank2_d;
    logic       ras_n_q, ras_n_d;
    logic       mux_q, mux_d;
    logic       cas1_n_q, cas1_n_d;
    logic       cas2_n_q, cas2_n_d;
    logic       busrq_n_q, busrq_n_d;
    logic       abuf_n_q, abuf_n_d;
    logic       gnt_q, gnt_d;

    logic w_rfsh_req;
    logic w_acc_req;
    logic w_idle;

    assign w_rfsh_req = !BMREQ_N && !BRFSH_N;
    assign w_acc_req  = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR) &&
                        (INTRAM_SEL || EXPRAM_SEL);
    assign w_idle     = (cyc_q == S_IDLE);

    always_comb begin
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        bank2_d  = bank2_q;
        ras_n_d  = ras_n_q;
        mux_d    = mux_q;
        cas1_n_d = cas1_n_q;
        cas2_n_d = cas2_n_q;
        case (cyc_q)
            S_IDLE: begin
                // Refresh outranks an access seen on the same edge.
                if (w_rfsh_req) begin
                    cyc_d   = S_RFSH;
                    ras_n_d = 1'b0;
                    mux_d   = 1'b0;
                    cnt_d   = c_RFSH_LOAD;
                end else if (w_acc_req) begin
                    cyc_d   = S_ROW;
                    ras_n_d = 1'b0;
                    bank2_d = !INTRAM_SEL;
                end
            end
            S_ROW: begin
                cyc_d = S_COL;
                mux_d = 1'b1;
            end
            S_COL: begin
                cyc_d    = S_HOLD;
                cas1_n_d = bank2_q;
                cas2_n_d = !bank2_q;
            end
            S_HOLD: begin
                if (BMREQ_N) begin
                    cyc_d    = S_PRECH;
                    ras_n_d  = 1'b1;
                    mux_d    = 1'b0;
                    cas1_n_d = 1'b1;
                    cas2_n_d = 1'b1;
                    cnt_d    = c_PRECH_LOAD;
                end
            end
            S_RFSH: begin
                if (cnt_q == 2'd0) begin
                    cyc_d   = S_PRECH;
                    ras_n_d = 1'b1;
                    cnt_d   = c_PRECH_LOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_PRECH: begin
                if (cnt_q == 2'd0) begin
                    cyc_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                cyc_d    = S_IDLE;
                ras_n_d  = 1'b1;
                mux_d    = 1'b0;
                cas1_n_d = 1'b1;
                cas2_n_d = 1'b1;
            end
        endcase
    end

    // The bus only changes hands while no DRAM cycle is in flight.
    always_comb begin
        arb_d     = arb_q;
        busrq_n_d = busrq_n_q;
        abuf_n_d  = abuf_n_q;
        gnt_d     = gnt_q;
        case (arb_q)
            A_CPU: begin
                if (!DMA_N && w_idle) begin
                    arb_d     = A_REQ;
                    busrq_n_d = 1'b0;
                end
            end
            A_REQ: begin
                if (!BUSAK_N) begin
                    arb_d    = A_DMA;
                    abuf_n_d = 1'b1;
                    gnt_d    = 1'b1;
                end else if (DMA_N) begin
                    arb_d     = A_CPU;
                    busrq_n_d = 1'b1;
                end
            end
            A_DMA: begin
                if (DMA_N && w_idle) begin
                    arb_d     = A_REL;
                    busrq_n_d = 1'b1;
                    gnt_d     = 1'b0;
                end
            end
            A_REL: begin
                if (BUSAK_N) begin
                    arb_d    = A_CPU;
                    abuf_n_d = 1'b0;
                end
            end
            default: begin
                arb_d     = A_CPU;
                busrq_n_d = 1'b1;
                abuf_n_d  = 1'b0;
                gnt_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            cyc_q     <= S_IDLE;
            arb_q     <= A_CPU;
            cnt_q     <= 2'd0;
            bank2_q   <= 1'b0;
            ras_n_q   <= 1'b1;
            mux_q     <= 1'b0;
            cas1_n_q  <= 1'b1;
            cas2_n_q  <= 1'b1;
            busrq_n_q <= 1'b1;
            abuf_n_q  <= 1'b0;
            gnt_q     <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            arb_q     <= arb_d;
            cnt_q     <= cnt_d;
            bank2_q   <= bank2_d;
            ras_n_q   <= ras_n_d;
            mux_q     <= mux_d;
            cas1_n_q  <= cas1_n_d;
            cas2_n_q  <= cas2_n_d;
            busrq_n_q <= busrq_n_d;
            abuf_n_q  <= abuf_n_d;
            gnt_q     <= gnt_d;
        end
    end

    assign RAS_N       = ras_n_q;
    assign MUX         = mux_q;
    assign CAS1_N      = cas1_n_q;
    assign CAS2_N      = cas2_n_q;
    assign RA7         = mux_q ? BA15 : BA7;
    assign BUSRQ_N     = busrq_n_q;
    assign ADDRBUFEN_N = abuf_n_q;
    assign DMA_GNT     = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mioc_dram_seq.sv
// ============================================================================
// Module   : tb_mioc_dram_seq
// Brief    : Randomized self-checking bench for mioc_dram_seq against a
//            transaction-level timing model of DRAM cycles and bus hand-over.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mioc_dram_seq;

    localparam int PRECH_CYC = 1;
    localparam int RFSH_CYC  = 2;

    logic clk;
    logic rst_n;
    logic bmreq_n, brd_n, n_bwr, brfsh_n, dma_n, busak_n;
    logic intram_sel, expram_sel, ba7, ba15;
    logic ras_n, mux, cas1_n, cas2_n, ra7, busrq_n, addrbufen_n, dma_gnt;

    int n_vec;
    int n_err;

    // Expected bus-handshake outputs and remaining precharge edges.
    logic m_busrq, m_abuf, m_gnt;
    int   prech_left;

    logic r_isel, r_esel, r_dmid;

    mioc_dram_seq #(
        .PRECH_CYC (PRECH_CYC),
        .RFSH_CYC  (RFSH_CYC)
    ) u_dut (
        .B_PHI       (clk),
        .RST_N       (rst_n),
        .BMREQ_N     (bmreq_n),
        .BRD_N       (brd_n),
        .N_BWR       (n_bwr),
        .BRFSH_N     (brfsh_n),
        .DMA_N       (dma_n),
        .BUSAK_N     (busak_n),
        .INTRAM_SEL  (intram_sel),
        .EXPRAM_SEL  (expram_sel),
        .BA7         (ba7),
        .BA15        (ba15),
        .RAS_N       (ras_n),
        .MUX         (mux),
        .CAS1_N      (cas1_n),
        .CAS2_N      (cas2_n),
        .RA7         (ra7),
        .BUSRQ_N     (busrq_n),
        .ADDRBUFEN_N (addrbufen_n),
        .DMA_GNT     (dma_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got={ras,mux,cas1,cas2,ra7,busrq,abuf,gnt}=%b exp=%b t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock edge. idle_pre says whether no DRAM cycle was in flight
    // when the edge sampled the inputs.
    task automatic step(input string tag, input logic idle_pre,
                        input logic e_ras, input logic e_mux,
                        input logic e_c1, input logic e_c2);
        if (m_busrq && !m_abuf && !m_gnt) begin
            if (!dma_n && idle_pre) m_busrq = 1'b0;
        end else if (!m_busrq && !m_gnt) begin
            if (!busak_n) begin
                m_abuf = 1'b1;
                m_gnt  = 1'b1;
            end else if (dma_n) begin
                m_busrq = 1'b1;
            end
        end else if (m_gnt) begin
            if (dma_n && idle_pre) begin
                m_busrq = 1'b1;
                m_gnt   = 1'b0;
            end
        end else begin
            if (busak_n) m_abuf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk(tag, {ras_n, mux, cas1_n, cas2_n, ra7, busrq_n, addrbufen_n, dma_gnt},
                 {e_ras, e_mux, e_c1, e_c2, (e_mux ? ba15 : ba7), m_busrq, m_abuf, m_gnt});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            logic ip;
            ip = (prech_left == 0);
            if (prech_left > 0) prech_left--;
            step("idle", ip, 1'b1, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic access(input logic isel, input logic esel, input logic wr,
                          input logic b7, input logic b15, input int h,
                          input logic dma_mid);
        logic use_c1;
        use_c1     = isel;
        ba7        = b7;
        ba15       = b15;
        intram_sel = isel;
        expram_sel = esel;
        brfsh_n    = 1'b1;
        brd_n      = wr;
        n_bwr      = !wr;
        bmreq_n    = 1'b0;
        while (prech_left > 0) begin
            prech_left--;
            step("acc_wait_prech", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        step("acc_row", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        if (dma_mid) dma_n = 1'b0;
        step("acc_col", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k <= h; k++)
            step("acc_cas", 1'b0, 1'b0, 1'b1, !use_c1, use_c1);
        bmreq_n = 1'b1;
        brd_n   = 1'b1;
        n_bwr   = 1'b1;
        step("acc_release", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        prech_left = PRECH_CYC;
    endtask

    task automatic refresh();
        intram_sel = 1'($urandom_range(0, 1));
        expram_sel = 1'($urandom_range(0, 1));
        brd_n      = 1'($urandom_range(0, 1));
        brfsh_n    = 1'b0;
        bmreq_n    = 1'b0;
        while (prech_left > 0) begin
            prech_left--;
            step("rf_wait_prech", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        step("rf_ras", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        bmreq_n = 1'b1;
        brfsh_n = 1'b1;
        brd_n   = 1'b1;
        for (int k = 1; k < RFSH_CYC; k++)
            step("rf_ras", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("rf_end", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        prech_left = PRECH_CYC;
    endtask

    // Requests that must not start a DRAM cycle.
    task automatic nosel(input logic no_rw);
        int n;
        intram_sel = no_rw;
        expram_sel = 1'b0;
        brfsh_n    = 1'b1;
        brd_n      = no_rw;
        n_bwr      = 1'b1;
        bmreq_n    = 1'b0;
        n = prech_left + 2;
        idle(n);
        bmreq_n = 1'b1;
        brd_n   = 1'b1;
    endtask

    // Plays the 6801/Z80 side of the hand-over one move at a time.
    task automatic arb_poke();
        if (m_busrq && !m_abuf && !m_gnt) begin
            dma_n = 1'b0;
        end else if (!m_busrq && !m_gnt) begin
            if ($urandom_range(0, 3) == 0) dma_n = 1'b1;
            else busak_n = 1'b0;
        end else if (m_gnt) begin
            if ($urandom_range(0, 1) == 1) dma_n = 1'b1;
        end else begin
            busak_n = 1'b1;
        end
        idle(1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_busrq = 1'b1;
        m_abuf  = 1'b0;
        m_gnt   = 1'b0;
        prech_left = 0;
        bmreq_n = 1'b1; brd_n = 1'b1; n_bwr = 1'b1; brfsh_n = 1'b1;
        dma_n = 1'b1; busak_n = 1'b1;
        intram_sel = 1'b0; expram_sel = 1'b0; ba7 = 1'b0; ba15 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset", {ras_n, mux, cas1_n, cas2_n, ra7, busrq_n, addrbufen_n, dma_gnt},
                     8'b1011_0100);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Internal-RAM read with row/column MSB distinct.
        access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        // Refresh wins even with an access qualifier present.
        refresh();
        idle(2);

        // Full DMA hand-over from idle, with a cycle run by the DMA master.
        dma_n = 1'b0;
        idle(1);
        busak_n = 1'b0;
        idle(1);
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        idle(prech_left);
        dma_n = 1'b1;
        idle(1);
        busak_n = 1'b1;
        idle(1);

        // DMA request arriving mid-way through an expansion-RAM write.
        access(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        idle(PRECH_CYC + 2);
        busak_n = 1'b0;
        idle(1);
        dma_n = 1'b1;
        idle(1);
        busak_n = 1'b1;
        idle(1);

        // Back-to-back accesses; both selects set picks the internal bank.
        access(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        access(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        nosel(1'b0);
        nosel(1'b1);

        // Asynchronous reset pulse while CAS is held.
        idle(prech_left);
        ba7 = 1'b1; ba15 = 1'b0;
        intram_sel = 1'b1; expram_sel = 1'b0;
        brd_n = 1'b0; bmreq_n = 1'b0;
        step("rst_row", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("rst_col", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst_cas", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hold", {ras_n, mux, cas1_n, cas2_n, ra7, busrq_n, addrbufen_n, dma_gnt},
                            8'b1011_1100);
        bmreq_n = 1'b1;
        brd_n   = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_busrq = 1'b1; m_abuf = 1'b0; m_gnt = 1'b0;
        prech_left = 0;
        access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        for (int it = 0; it < 200; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                r_isel = 1'($urandom_range(0, 1));
                r_esel = r_isel ? 1'($urandom_range(0, 1)) : 1'b1;
                r_dmid = (m_busrq && !m_abuf && !m_gnt && dma_n &&
                          ($urandom_range(0, 3) == 0));
                access(r_isel, r_esel, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), r_dmid);
            end else if (op == 5) begin
                refresh();
            end else if (op == 6) begin
                nosel(1'($urandom_range(0, 1)));
            end else if (op == 7) begin
                idle($urandom_range(0, 3));
            end else begin
                arb_poke();
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
